prog_sequencer: RTL and testbench
=================================

// Module: prog_sequencer
// PURPOSE
//  Sequential run controller sitting between the instruction decoder and the program counter /
//  instruction ROM. It owns the PC and the Start/Done program handshake. It stalls multi-cycle
//  data-memory loads, resolves relative and LUT branches, and gates architectural writes
//  (ExecEn) so the decoder's RegWrEn/MemWrEn take effect only on committing cycles.
//  It also keeps a per-run cycle counter for performance reporting.
// PARAMETERS
//  PC_W       10  width of program counter (instruction ROM depth 2**PC_W)
//  OFF_W       6  width of signed relative branch offset
//  MEM_LAT     2  extra cycles a load occupies data memory (0 = single-cycle load)
//  CNT_W      16  width of CycleCount
//  START_ADDR  0  PC value on reset / Start
// PORTS
//  Clk        in   1      clock, rising edge
//  Reset      in   1      asynchronous, active-low reset
//  Start      in   1      level; high = hold/abort and rearm, falling edge launches program
//  BranchEn   in   1      from decoder: current instr is a branch
//  Jump       in   1      from decoder: 1 = LUT target, 0 = relative offset
//  Taken      in   1      from ALU flag: branch condition satisfied
//  Offset     in   OFF_W  signed relative offset from instr field
//  LutTarget  in   PC_W   absolute target from branch LUT
//  LoadInst   in   1      from decoder: current instr is a load
//  Ack        in   1      from decoder: program-end instruction
//  PC         out  PC_W   instruction ROM address
//  ExecEn     out  1      1 = current instr commits (AND into RegWrEn/MemWrEn)
//  Done       out  1      program finished, held until next Start
//  CycleCount out  CNT_W  cycles spent in RUN+STALL for latest run
// BEHAVIOUR
//  States: IDLE, RUN, STALL, DONE. Reset (Reset=0, async): state=IDLE, PC=START_ADDR,
//   ExecEn=0, Done=0, CycleCount=0, stall counter=0.
//  Start=1 in any state (highest priority after reset): next state IDLE, PC<=START_ADDR,
//   Done<=0. An in-flight load stall is discarded; no commit occurs.
//  IDLE: ExecEn=0. Start=0 -> RUN next cycle; CycleCount<=0 on that transition.
//  RUN: CycleCount increments every cycle.
//   Ack=1: ExecEn=0, PC held, ->DONE. Ack takes priority over branch/load fields.
//   LoadInst=1 and MEM_LAT>0: ExecEn=0, PC held, stall counter<=MEM_LAT, ->STALL.
//   Otherwise ExecEn=1 and PC advances:
//    BranchEn&Taken&Jump  -> PC<=LutTarget
//    BranchEn&Taken&~Jump -> PC<=PC+sign_extend(Offset)
//    else                 -> PC<=PC+1
//   BranchEn with Taken=0 commits as PC+1.
//  STALL: PC held and CycleCount increments.
//   Counter decrements each cycle. While counter>1, ExecEn=0.
//   On counter==1: ExecEn=1, PC<=PC+1, ->RUN.
//   A load therefore occupies exactly MEM_LAT+1 cycles and commits once, on its last cycle.
//   Decoder inputs are ignored in STALL; the instruction is stable because PC is held.
//  DONE: Done=1, ExecEn=0, PC and CycleCount frozen. The block stays in DONE until Start=1.
//  Arithmetic: PC math is modulo 2**PC_W. Wrap from all-ones to 0 is legal and unflagged.
//   Negative offsets wrap the same way.
//  CycleCount saturates at all-ones and never wraps.
//  ExecEn and Done are combinational from state/counter; PC and CycleCount are registered.
// TESTING
//  1 Reset low mid-RUN (PC=0x05) -> PC=0, Done=0, ExecEn=0 immediately, without waiting for a Clk edge.
//  2 Start 1->0, then three plain instrs and Ack -> PC 0,1,2,3 then held at 3.
//    Done=1 from the cycle after Ack; CycleCount=4.
//  3 PC=0x10, BranchEn=1, Taken=1, Jump=0, Offset=-3 -> PC=0x0D.
//    Same with Jump=1, LutTarget=0x2A3 -> PC=0x2A3. Taken=0 -> PC=0x11.
//  4 MEM_LAT=2, load at PC=7 -> ExecEn 0,0,1 over 3 cycles, PC=7,7,7 then 8; exactly one commit.
//  5 Start=1 during STALL -> IDLE next cycle, PC=0, no ExecEn pulse; restart runs cleanly.
//  6 PC=all-ones, plain instr -> PC=0. CycleCount forced near max -> saturates at 0xFFFF.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program run controller: owns the PC, the start/done handshake, load stalls,
// branch resolution, architectural-write gating and a per-run cycle counter.
module prog_sequencer #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned OFF_W      = 6,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned START_ADDR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             branch_en,
    input  logic             jump,
    input  logic             taken,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  lut_target,
    input  logic             load_inst,
    input  logic             ack,
    output logic [PC_W-1:0]  pc,
    output logic             exec_en,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned LAT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] cnt_nxt, cnt_inc;
    logic [LAT_W-1:0] stall_cnt, stall_nxt;
    logic [PC_W-1:0]  off_ext;

    assign off_ext = PC_W'(signed'(offset));
    assign cnt_inc = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= PC_W'(START_ADDR);
            cycle_count <= '0;
            stall_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            cycle_count <= cnt_nxt;
            stall_cnt   <= stall_nxt;
        end
    end

    // Next-state, next-PC and commit gating
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cycle_count;
        stall_nxt = stall_cnt;
        exec_en   = 1'b0;
        done      = (state == S_DONE);

        if (start) begin
            state_nxt = S_IDLE;
            pc_nxt    = PC_W'(START_ADDR);
            stall_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end
                S_RUN: begin
                    cnt_nxt = cnt_inc;
                    if (ack) begin
                        state_nxt = S_DONE;
                    end else if (load_inst && (MEM_LAT > 0)) begin
                        stall_nxt = LAT_W'(MEM_LAT);
                        state_nxt = S_STALL;
                    end else begin
                        exec_en = 1'b1;
                        if (branch_en && taken && jump)
                            pc_nxt = lut_target;
                        else if (branch_en && taken)
                            pc_nxt = pc + off_ext;
                        else
                            pc_nxt = pc + PC_W'(1);
                    end
                end
                S_STALL: begin
                    cnt_nxt   = cnt_inc;
                    stall_nxt = stall_cnt - LAT_W'(1);
                    // The load commits only on its final occupied cycle
                    if (stall_cnt == LAT_W'(1)) begin
                        exec_en   = 1'b1;
                        pc_nxt    = pc + PC_W'(1);
                        state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                    state_nxt = S_DONE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: cycle-level reference model plus directed scenarios
// with hand-computed expectations.
module tb_prog_sequencer;

    localparam int unsigned PC_W    = 10;
    localparam int unsigned OFF_W   = 6;
    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned CNT_W   = 16;
    localparam int          PC_MASK = (1 << PC_W) - 1;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             branch_en;
    logic             jump;
    logic             taken;
    logic [OFF_W-1:0] offset;
    logic [PC_W-1:0]  lut_target;
    logic             load_inst;
    logic             ack;
    logic [PC_W-1:0]  pc;
    logic             exec_en;
    logic             done;
    logic [CNT_W-1:0] cycle_count;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    prog_sequencer #(
        .PC_W(PC_W), .OFF_W(OFF_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W), .START_ADDR(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .branch_en(branch_en), .jump(jump),
        .taken(taken), .offset(offset), .lut_target(lut_target), .load_inst(load_inst),
        .ack(ack), .pc(pc), .exec_en(exec_en), .done(done), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase, PC, cycle count and cycles already spent on a pending load
    int m_phase;
    int m_pc;
    int m_cnt;
    int m_spent;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= PH_IDLE;
            m_pc    <= 0;
            m_cnt   <= 0;
            m_spent <= 0;
        end else if (start) begin
            m_phase <= PH_IDLE;
            m_pc    <= 0;
            m_spent <= 0;
        end else if (m_phase == PH_IDLE) begin
            m_phase <= PH_RUN;
            m_cnt   <= 0;
        end else if (m_phase == PH_RUN) begin
            m_cnt <= (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (m_spent > 0 || (load_inst && !ack)) begin
                if (m_spent == int'(MEM_LAT)) begin
                    m_pc    <= (m_pc + 1) & PC_MASK;
                    m_spent <= 0;
                end else begin
                    m_spent <= m_spent + 1;
                end
            end else if (ack) begin
                m_phase <= PH_DONE;
            end else if (branch_en && taken) begin
                m_pc <= jump ? int'(lut_target) : (m_pc + int'($signed(offset))) & PC_MASK;
            end else begin
                m_pc <= (m_pc + 1) & PC_MASK;
            end
        end
    end

    function automatic bit exp_exec();
        if (!rst_n || start || m_phase != PH_RUN) return 1'b0;
        if (m_spent > 0 || (load_inst && !ack)) return (m_spent == int'(MEM_LAT));
        return !ack;
    endfunction

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_pc", 32'(pc), 32'(m_pc));
            chk("model_cycle_count", 32'(cycle_count), 32'(m_cnt));
            chk("model_exec_en", 32'(exec_en), 32'(exp_exec()));
            chk("model_done", 32'(done), 32'(m_phase == PH_DONE));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plain();
        branch_en  = 1'b0;
        jump       = 1'b0;
        taken      = 1'b0;
        offset     = '0;
        lut_target = '0;
        load_inst  = 1'b0;
        ack        = 1'b0;
    endtask

    task automatic advance(input int n);
        plain();
        repeat (n) tick();
    endtask

    // Leaves the DUT in RUN with PC at the start address
    task automatic start_run();
        plain();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        plain();
        tick();
        cmp_on = 1'b1;
        tick();
        chk("reset_pc", 32'(pc), 32'h0);
        chk("reset_exec_en", 32'(exec_en), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_cycle_count", 32'(cycle_count), 32'h0);
        rst_n = 1'b1;
        tick();

        // Plain program of three instructions then Ack
        start_run();
        chk("run_pc0", 32'(pc), 32'h0);
        chk("run_exec0", 32'(exec_en), 32'h1);
        tick();
        chk("run_pc1", 32'(pc), 32'h1);
        tick();
        chk("run_pc2", 32'(pc), 32'h2);
        tick();
        chk("run_pc3", 32'(pc), 32'h3);
        ack = 1'b1;
        #1;
        chk("ack_exec_en", 32'(exec_en), 32'h0);
        tick();
        ack = 1'b0;
        chk("done_set", 32'(done), 32'h1);
        chk("done_pc_held", 32'(pc), 32'h3);
        chk("done_cycle_count", 32'(cycle_count), 32'h4);
        tick();
        chk("done_hold", 32'(done), 32'h1);
        chk("done_cnt_frozen", 32'(cycle_count), 32'h4);

        // Asynchronous reset mid-run
        start_run();
        advance(5);
        chk("pre_reset_pc", 32'(pc), 32'h5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_pc", 32'(pc), 32'h0);
        chk("async_reset_done", 32'(done), 32'h0);
        chk("async_reset_exec", 32'(exec_en), 32'h0);
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        // Branches: relative backwards, LUT jump, not-taken
        start_run();
        advance(16);
        branch_en = 1'b1;
        taken     = 1'b1;
        jump      = 1'b0;
        offset    = 6'h3D;
        #1;
        chk("branch_exec_en", 32'(exec_en), 32'h1);
        tick();
        chk("branch_rel_neg", 32'(pc), 32'h00D);
        jump       = 1'b1;
        lut_target = 10'h2A3;
        tick();
        chk("branch_lut", 32'(pc), 32'h2A3);
        lut_target = 10'h010;
        tick();
        chk("branch_lut_back", 32'(pc), 32'h010);
        taken = 1'b0;
        jump  = 1'b0;
        tick();
        chk("branch_not_taken", 32'(pc), 32'h011);

        // Negative offset wrapping below zero
        start_run();
        advance(1);
        branch_en = 1'b1;
        taken     = 1'b1;
        offset    = 6'h3D;
        tick();
        chk("branch_wrap_neg", 32'(pc), 32'h3FE);

        // Load stall: three cycles at PC 7, one commit on the last
        start_run();
        advance(7);
        load_inst = 1'b1;
        #1;
        chk("load_exec_c0", 32'(exec_en), 32'h0);
        chk("load_pc_c0", 32'(pc), 32'h7);
        tick();
        ack = 1'b1;
        #1;
        chk("load_exec_c1", 32'(exec_en), 32'h0);
        chk("load_pc_c1", 32'(pc), 32'h7);
        tick();
        chk("load_exec_c2", 32'(exec_en), 32'h1);
        chk("load_pc_c2", 32'(pc), 32'h7);
        tick();
        plain();
        chk("load_pc_after", 32'(pc), 32'h8);
        chk("load_not_done", 32'(done), 32'h0);

        // Start during a stall aborts without committing
        start_run();
        advance(3);
        load_inst = 1'b1;
        tick();
        load_inst = 1'b0;
        start     = 1'b1;
        #1;
        chk("abort_exec_en", 32'(exec_en), 32'h0);
        tick();
        chk("abort_pc", 32'(pc), 32'h0);
        chk("abort_idle_exec", 32'(exec_en), 32'h0);
        start = 1'b0;
        tick();
        advance(2);
        chk("restart_pc", 32'(pc), 32'h2);
        chk("restart_cnt", 32'(cycle_count), 32'h2);

        // PC wrap and cycle counter saturation
        start_run();
        advance(1023);
        chk("pc_all_ones", 32'(pc), 32'h3FF);
        tick();
        chk("pc_wrap", 32'(pc), 32'h0);
        advance(65540 - 1024);
        chk("cnt_saturated", 32'(cycle_count), 32'hFFFF);
        chk("pc_after_long_run", 32'(pc), 32'h4);
        ack = 1'b1;
        tick();
        plain();
        chk("sat_done", 32'(done), 32'h1);
        chk("sat_cnt_held", 32'(cycle_count), 32'hFFFF);
        tick();

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
